// File: rtl/host_cmd_master_pkg.sv
// Shared definitions for the host command master: frame opcodes, command
// encodings and controller state encoding.
package host_cmd_master_pkg;

  localparam logic [7:0] FRAME_WR  = 8'hAA;
  localparam logic [7:0] FRAME_RD  = 8'hBB;
  localparam logic [7:0] FRAME_ALU = 8'hCC;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_RD  = 2'd1,
    OP_ALU = 2'd2,
    OP_ILL = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RECV    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Number of bytes transmitted for a command with nb bytes per field.
  function automatic int frame_len(input cmd_op_e op, input int nb);
    case (op)
      OP_WR:   return 1 + 2 * nb;
      OP_RD:   return 1 + nb;
      OP_ALU:  return 2 + 2 * nb;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/hcm_rsp_timer.sv
// Response inactivity timer: cleared on demand, counts while enabled and
// flags expiry on the LIMIT-th counted cycle.
module hcm_rsp_timer
  import host_cmd_master_pkg::*;
#(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(LIMIT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/host_cmd_master.sv
// Host command master: serialises register/ALU commands into UART byte
// frames and assembles the byte response, with a response timeout.
module host_cmd_master
  import host_cmd_master_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RSP_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  output logic                    CMD_RDY,
  input  logic [1:0]              CMD_OP,
  input  logic [DATA_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPB,
  input  logic [3:0]              CMD_FUN,
  output logic [7:0]              TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    Busy,
  input  logic [7:0]              RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    RSP_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_ERR
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int FW = 8 * (2 * NB + 2);
  localparam int CW = $clog2(2 * NB + 3);
  localparam int RW = 2 * DATA_WIDTH;

  state_e                  state_q, state_d;
  cmd_op_e                 op_q, op_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d, data_q, data_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [3:0]              fun_q, fun_d;
  logic [CW-1:0]           byte_cnt_q, byte_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [RW-1:0]           rsp_acc_q, rsp_acc_d, rsp_data_q, rsp_data_d;
  logic                    rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [7:0]              tx_p_data_q, tx_p_data_d;
  logic                    tx_d_vld_q, tx_d_vld_d;
  logic                    cmd_rdy_q, cmd_rdy_d;

  logic [FW-1:0]           frame_vec, frame_shift;
  logic [7:0]              tx_byte;
  logic [CW-1:0]           tx_len, rx_len;
  logic                    timer_clr, timer_en, timer_expired;

  hcm_rsp_timer #(
    .LIMIT (RSP_TIMEOUT)
  ) u_rsp_timer (
    .clk     (clk),
    .RST     (RST),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Whole frame laid out LSB-byte-first; the byte counter picks the next byte.
  always_comb begin
    frame_vec = '0;
    case (op_q)
      OP_WR:   frame_vec = FW'({data_q, addr_q, FRAME_WR});
      OP_RD:   frame_vec = FW'({addr_q, FRAME_RD});
      OP_ALU:  frame_vec = FW'({4'b0000, fun_q, opb_q, opa_q, FRAME_ALU});
      default: frame_vec = '0;
    endcase
    frame_shift = frame_vec >> {byte_cnt_q, 3'b000};
    tx_byte     = frame_shift[7:0];
    tx_len      = CW'(frame_len(op_q, NB));
    rx_len      = (op_q == OP_ALU) ? CW'(2 * NB) : CW'(NB);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    fun_d       = fun_q;
    byte_cnt_d  = byte_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rsp_acc_d   = rsp_acc_q;
    rsp_data_d  = rsp_data_q;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = rsp_err_q;
    tx_p_data_d = tx_p_data_q;
    tx_d_vld_d  = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VLD && cmd_rdy_q) begin
          op_d       = cmd_op_e'(CMD_OP);
          addr_d     = CMD_ADDR;
          data_d     = CMD_DATA;
          opa_d      = CMD_OPA;
          opb_d      = CMD_OPB;
          fun_d      = CMD_FUN;
          byte_cnt_d = '0;
          rx_cnt_d   = '0;
          rsp_acc_d  = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (op_q == OP_ILL) begin
          state_d    = ST_DONE;
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = rsp_acc_q;
        end else if (!Busy) begin
          tx_p_data_d = tx_byte;
          tx_d_vld_d  = 1'b1;
          byte_cnt_d  = byte_cnt_q + CW'(1);
          state_d     = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (Busy) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!Busy) begin
          if (byte_cnt_q != tx_len) begin
            state_d = ST_SEND;
          end else if (op_q == OP_WR) begin
            state_d    = ST_DONE;
            rsp_vld_d  = 1'b1;
            rsp_err_d  = 1'b0;
            rsp_data_d = rsp_acc_q;
          end else begin
            state_d   = ST_RECV;
            rx_cnt_d  = '0;
            timer_clr = 1'b1;
          end
        end
      end
      ST_RECV: begin
        timer_en = 1'b1;
        // A byte arriving on the expiry cycle wins over the timeout.
        if (RX_D_VLD) begin
          rsp_acc_d = rsp_acc_q | (RW'(RX_P_DATA) << {rx_cnt_q, 3'b000});
          rx_cnt_d  = rx_cnt_q + CW'(1);
          timer_clr = 1'b1;
          if (rx_cnt_q + CW'(1) == rx_len) begin
            state_d    = ST_DONE;
            rsp_vld_d  = 1'b1;
            rsp_err_d  = 1'b0;
            rsp_data_d = rsp_acc_d;
          end
        end else if (timer_expired) begin
          state_d    = ST_DONE;
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = rsp_acc_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WR;
      addr_q      <= '0;
      data_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      byte_cnt_q  <= '0;
      rx_cnt_q    <= '0;
      rsp_acc_q   <= '0;
      rsp_data_q  <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      tx_p_data_q <= '0;
      tx_d_vld_q  <= 1'b0;
      cmd_rdy_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      fun_q       <= fun_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      rsp_acc_q   <= rsp_acc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      tx_p_data_q <= tx_p_data_d;
      tx_d_vld_q  <= tx_d_vld_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  assign CMD_RDY   = cmd_rdy_q;
  assign TX_P_DATA = tx_p_data_q;
  assign TX_D_VLD  = tx_d_vld_q;
  assign RSP_VLD   = rsp_vld_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_host_cmd_master.sv
// Directed bench for host_cmd_master: UART busy model, byte responder and
// hand-computed frames, latencies and response values.
module tb_host_cmd_master;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          CMD_VLD = 1'b0;
  logic          CMD_RDY;
  logic [1:0]    CMD_OP = 2'd0;
  logic [DW-1:0] CMD_ADDR = '0, CMD_DATA = '0, CMD_OPA = '0, CMD_OPB = '0;
  logic [3:0]    CMD_FUN = 4'd0;
  logic [7:0]    TX_P_DATA;
  logic          TX_D_VLD;
  logic          Busy = 1'b0;
  logic [7:0]    RX_P_DATA = 8'd0;
  logic          RX_D_VLD = 1'b0;
  logic          RSP_VLD;
  logic [2*DW-1:0] RSP_DATA;
  logic          RSP_ERR;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_n = 0;
  int fall_cyc = 0;
  int busy_viol = 0;
  logic [7:0] tx_log[$];

  logic [2*DW-1:0] got_data;
  logic            got_err;
  logic            got_rdy;

  host_cmd_master #(
    .DATA_WIDTH  (DW),
    .RSP_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .CMD_VLD   (CMD_VLD),
    .CMD_RDY   (CMD_RDY),
    .CMD_OP    (CMD_OP),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_DATA  (CMD_DATA),
    .CMD_OPA   (CMD_OPA),
    .CMD_OPB   (CMD_OPB),
    .CMD_FUN   (CMD_FUN),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .Busy      (Busy),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .RSP_VLD   (RSP_VLD),
    .RSP_DATA  (RSP_DATA),
    .RSP_ERR   (RSP_ERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TX byte monitor; Busy is sampled before the busy model updates it.
  initial begin
    forever begin
      @(negedge clk);
      if (TX_D_VLD === 1'b1) begin
        tx_log.push_back(TX_P_DATA);
        if (Busy) busy_viol++;
      end
    end
  end

  // UART transmitter model: 10 busy cycles per byte.
  initial begin
    forever begin
      @(negedge clk);
      if (TX_D_VLD === 1'b1) begin
        #1 Busy = 1'b1;
        repeat (10) @(negedge clk);
        #1 Busy = 1'b0;
        fall_n++;
        fall_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                       output int acc_cyc);
    int n;
    n = 0;
    while (CMD_RDY !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val("rdy_wait", 32'(n < 100), 32'd1);
    CMD_VLD = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_DATA = d;
    CMD_OPA = oa; CMD_OPB = ob; CMD_FUN = f;
    acc_cyc = cyc;
    @(posedge clk); #1;
    CMD_VLD = 1'b0;
  endtask

  task automatic wait_rsp(input int lim, output int rcyc);
    int n;
    logic seen;
    n = 0; seen = 1'b0; rcyc = 0;
    while (!seen && n < lim) begin
      @(negedge clk);
      if (RSP_VLD === 1'b1) begin
        seen = 1'b1; rcyc = cyc;
        got_data = RSP_DATA; got_err = RSP_ERR; got_rdy = CMD_RDY;
      end
      n++;
    end
    chk_val("rsp_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_falls(input int target);
    int n;
    n = 0;
    while (fall_n < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val("tx_frame_wait", 32'(fall_n >= target), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, output int rx_cyc);
    RX_P_DATA = b; RX_D_VLD = 1'b1; rx_cyc = cyc;
    @(posedge clk); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic chk_tx(input string tag, input int base, input int n, input logic [31:0] exp);
    logic [31:0] e;
    chk_val({tag, "_cnt"}, 32'(tx_log.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp >> (8 * i);
      if (base + i < tx_log.size())
        chk_val({tag, "_byte"}, 32'(tx_log[base + i]), 32'(e[7:0]));
    end
  endtask

  initial begin
    int acc_c, rsp_c, rx_c, base, fb, n, fcyc;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk_val("rst_rdy", 32'(CMD_RDY), 32'd1);
    chk_val("rst_txv", 32'(TX_D_VLD), 32'd0);
    chk_val("rst_txd", 32'(TX_P_DATA), 32'd0);
    chk_val("rst_rspv", 32'(RSP_VLD), 32'd0);
    chk_val("rst_rspd", 32'(RSP_DATA), 32'd0);
    chk_val("rst_rspe", 32'(RSP_ERR), 32'd0);
    RST = 1'b1;
    @(posedge clk); #1;

    // Write; extra CMD_VLD while busy and a stray RX byte are both ignored
    base = tx_log.size();
    issue(2'd0, 8'h05, 8'h3C, 8'h00, 8'h00, 4'h0, acc_c);
    chk_val("wr_rdy_low", 32'(CMD_RDY), 32'd0);
    CMD_VLD = 1'b1; CMD_OP = 2'd1;
    repeat (3) begin @(posedge clk); #1; end
    CMD_VLD = 1'b0;
    send_rx(8'hFF, rx_c);
    wait_rsp(300, rsp_c);
    chk_val("wr_err", 32'(got_err), 32'd0);
    chk_val("wr_data", 32'(got_data), 32'd0);
    chk_tx("wr_tx", base, 3, 32'h003C05AA);
    chk_val("rdy_after_rsp", 32'(CMD_RDY), 32'd1);
    repeat (20) begin @(posedge clk); #1; end
    chk_val("wr_not_queued", 32'(tx_log.size() - base), 32'd3);
    $display("txn write addr=05 data=3c rsp=%0h err=%0b", got_data, got_err);

    // Read; RX byte during SEND is ignored
    base = tx_log.size(); fb = fall_n;
    issue(2'd1, 8'h07, 8'h00, 8'h00, 8'h00, 4'h0, acc_c);
    send_rx(8'h77, rx_c);
    wait_falls(fb + 2);
    repeat (2) begin @(posedge clk); #1; end
    send_rx(8'h9A, rx_c);
    wait_rsp(50, rsp_c);
    chk_val("rd_lat", 32'(rsp_c - rx_c), 32'd1);
    chk_val("rd_data", 32'(got_data), 32'h009A);
    chk_val("rd_err", 32'(got_err), 32'd0);
    chk_tx("rd_tx", base, 2, 32'h000007BB);
    $display("txn read addr=07 rsp=%0h err=%0b", got_data, got_err);

    // ALU
    base = tx_log.size(); fb = fall_n;
    issue(2'd2, 8'h00, 8'h00, 8'h12, 8'h34, 4'h1, acc_c);
    wait_falls(fb + 4);
    send_rx(8'hDE, rx_c);
    @(posedge clk); #1;
    send_rx(8'h00, rx_c);
    wait_rsp(50, rsp_c);
    chk_val("alu_lat", 32'(rsp_c - rx_c), 32'd1);
    chk_val("alu_data", 32'(got_data), 32'h00DE);
    chk_val("alu_err", 32'(got_err), 32'd0);
    chk_tx("alu_tx", base, 4, 32'h013412CC);
    $display("txn alu opa=12 opb=34 fun=1 rsp=%0h err=%0b", got_data, got_err);

    // Illegal opcode
    base = tx_log.size();
    issue(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, acc_c);
    wait_rsp(20, rsp_c);
    chk_val("ill_lat", 32'(rsp_c - acc_c), 32'd2);
    chk_val("ill_err", 32'(got_err), 32'd1);
    chk_val("ill_data", 32'(got_data), 32'd0);
    chk_val("ill_no_tx", 32'(tx_log.size() - base), 32'd0);
    $display("txn illegal rsp=%0h err=%0b", got_data, got_err);

    // Read timeout
    base = tx_log.size(); fb = fall_n;
    issue(2'd1, 8'h03, 8'h00, 8'h00, 8'h00, 4'h0, acc_c);
    wait_falls(fb + 2);
    fcyc = fall_cyc;
    wait_rsp(100, rsp_c);
    chk_val("to_lat", 32'(rsp_c - (fcyc + 1)), 32'd16);
    chk_val("to_err", 32'(got_err), 32'd1);
    chk_val("to_rdy_during", 32'(got_rdy), 32'd0);
    chk_val("to_rdy_after", 32'(CMD_RDY), 32'd1);
    $display("txn read-timeout addr=03 rsp=%0h err=%0b", got_data, got_err);

    // ALU timeout with a partial response kept
    fb = fall_n;
    issue(2'd2, 8'h00, 8'h00, 8'hA5, 8'h5A, 4'hF, acc_c);
    wait_falls(fb + 4);
    send_rx(8'h55, rx_c);
    wait_rsp(100, rsp_c);
    chk_val("part_lat", 32'(rsp_c - rx_c), 32'd17);
    chk_val("part_data", 32'(got_data), 32'h0055);
    chk_val("part_err", 32'(got_err), 32'd1);
    $display("txn alu-timeout rsp=%0h err=%0b", got_data, got_err);

    // Reset after the second byte of an ALU frame
    base = tx_log.size();
    issue(2'd2, 8'h00, 8'h00, 8'h12, 8'h34, 4'h1, acc_c);
    n = 0;
    while (tx_log.size() < base + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val("mid_two_bytes", 32'(tx_log.size() - base), 32'd2);
    RST = 1'b0;
    @(posedge clk); #1;
    chk_val("mid_txv", 32'(TX_D_VLD), 32'd0);
    chk_val("mid_txd", 32'(TX_P_DATA), 32'd0);
    chk_val("mid_rspv", 32'(RSP_VLD), 32'd0);
    chk_val("mid_rspd", 32'(RSP_DATA), 32'd0);
    chk_val("mid_rspe", 32'(RSP_ERR), 32'd0);
    chk_val("mid_rdy", 32'(CMD_RDY), 32'd1);
    @(posedge clk); #1;
    RST = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk_val("mid_no_more_tx", 32'(tx_log.size() - base), 32'd2);
    $display("txn alu-abandoned-by-reset bytes=%0d", tx_log.size() - base);

    // Write after reset
    base = tx_log.size();
    issue(2'd0, 8'h11, 8'h22, 8'h00, 8'h00, 4'h0, acc_c);
    wait_rsp(300, rsp_c);
    chk_val("wr2_err", 32'(got_err), 32'd0);
    chk_val("wr2_data", 32'(got_data), 32'd0);
    chk_tx("wr2_tx", base, 3, 32'h002211AA);
    chk_val("busy_violations", 32'(busy_viol), 32'd0);
    $display("txn write addr=11 data=22 rsp=%0h err=%0b", got_data, got_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of address, data and operand fields; SHALL be a multiple of 8; NB = DATA_WIDTH/8 bytes per field.
REQ-002 Parameter RSP_TIMEOUT, default 4096, clk cycles allowed between response bytes.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 RST  in  1  reset; synchronous, active-low.
REQ-005 CMD_VLD  in  1  command request.
REQ-006 CMD_RDY  out  1  block idle and accepting a command.
REQ-007 CMD_OP  in  2  0 = RF write, 1 = RF read, 2 = ALU, 3 = illegal.
REQ-008 CMD_ADDR, CMD_DATA, CMD_OPA, CMD_OPB  in  DATA_WIDTH each  command fields.
REQ-009 CMD_FUN  in  4  ALU function.
REQ-010 TX_P_DATA  out  8  byte to UART transmitter.
REQ-011 TX_D_VLD  out  1  one-cycle byte strobe.
REQ-012 Busy  in  1  UART transmitter busy.
REQ-013 RX_P_DATA  in  8  byte from UART receiver.
REQ-014 RX_D_VLD  in  1  one-cycle received-byte strobe.
REQ-015 RSP_VLD  out  1  one-cycle completion pulse.
REQ-016 RSP_DATA  out  2*DATA_WIDTH  assembled response; held until the next RSP_VLD.
REQ-017 RSP_ERR  out  1  qualifies RSP_VLD: timeout or illegal opcode.

Function
REQ-018 Command accepted on a cycle with CMD_VLD=1 and CMD_RDY=1; all fields are captured that cycle; CMD_RDY=0 from the next cycle until the cycle after RSP_VLD.
REQ-019 Frames, multi-byte fields sent LSB byte first: write = 0xAA, ADDR, DATA; read = 0xBB, ADDR; ALU = 0xCC, OPA, OPB, {4'b0, FUN}.
REQ-020 Frame lengths: write 1+2NB bytes; read 1+NB bytes; ALU 2+2NB bytes, tracked by a byte counter.
REQ-021 States: IDLE, SEND, WAIT_HI, WAIT_LO, RECV, DONE.
REQ-022 SEND: when Busy=0, drive TX_P_DATA and assert TX_D_VLD for exactly one cycle, then go to WAIT_HI.
REQ-023 WAIT_HI: wait for Busy=1, then go to WAIT_LO.
REQ-024 WAIT_LO: on Busy=0, go to SEND if bytes remain; otherwise go to DONE (write) or RECV (read/ALU).
REQ-025 The first TX_D_VLD occurs no earlier than 1 cycle after acceptance.
REQ-026 RECV: expect NB bytes for read and 2NB bytes for ALU; place each RX_D_VLD byte into RSP_DATA LSB first; unused upper bytes are 0.
REQ-027 After the last byte go to DONE.
REQ-028 The timeout counter resets on entry to RECV and on every RX_D_VLD; reaching RSP_TIMEOUT goes to DONE with RSP_ERR=1 and keeps the partial RSP_DATA.
REQ-029 DONE lasts 1 cycle and asserts RSP_VLD, then returns to IDLE. Latency from last response byte strobe to RSP_VLD is 1 cycle.
REQ-030 Write completes with RSP_DATA=0 and RSP_ERR=0.
REQ-031 CMD_OP=3 is accepted with no bytes sent; DONE follows on the next cycle with RSP_ERR=1.
REQ-032 RX_D_VLD outside RECV is ignored.
REQ-033 An RX_D_VLD on the cycle the timeout expires is captured, and timeout is not flagged if it was the last byte.
REQ-034 CMD_VLD while CMD_RDY=0 is ignored and not queued.

Reset
REQ-035 On RST=0 at a clock edge: state IDLE, CMD_RDY=1 after release, TX_D_VLD=0, TX_P_DATA=0, RSP_VLD=0, RSP_ERR=0, RSP_DATA=0, counters 0.
REQ-036 Reset mid-frame abandons the frame immediately; no further TX_D_VLD occurs.

Structure
REQ-037 A shared package holds frame opcodes 0xAA/0xBB/0xCC, CMD_OP encodings and the state encoding.
REQ-038 One sub-module, hcm_rsp_timer, implements the loadable timeout counter; everything else stays in host_cmd_master.

Verification
REQ-039 DATA_WIDTH=8, write ADDR=0x05, DATA=0x3C, with a Busy model of 10 cycles per byte -> TX bytes AA,05,3C, each strobe sent only while Busy=0; then RSP_VLD=1, RSP_ERR=0, RSP_DATA=0.
REQ-040 Read ADDR=0x07, responder returns 0x9A -> TX bytes BB,07; then RSP_DATA=0x009A, RSP_VLD one cycle after the RX strobe.
REQ-041 ALU OPA=0x12, OPB=0x34, FUN=1, responder returns 0xDE then 0x00 -> TX bytes CC,12,34,01; then RSP_DATA=0x00DE.
REQ-042 Read with no response and RSP_TIMEOUT=16 -> RSP_VLD and RSP_ERR 16 cycles after RECV entry; CMD_RDY=1 on the next cycle.
REQ-043 RST=0 asserted after the second byte of an ALU frame -> no further TX_D_VLD; all outputs at reset values; a new write then completes normally.
REQ-044 CMD_OP=3 -> no TX_D_VLD; RSP_VLD and RSP_ERR two cycles after acceptance.
